// File: rtl/indexed_queue_mc.sv
// Multi-channel FIFO with lazy deletion: removes leave holes in place and a
// per-channel head scanner skips up to SCAN_SIZE holes each cycle.
module indexed_queue_mc #(
    parameter int DATA_SIZE = 64,
    parameter int FIFO_SIZE = 64,
    parameter int NUM_CH    = 4,
    parameter int SCAN_SIZE = 16,
    parameter int PTR_WIDTH = $clog2(FIFO_SIZE),
    parameter int CH_WIDTH  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [2:0]                      op_flag,
    input  logic [CH_WIDTH-1:0]             op_ch,
    input  logic [PTR_WIDTH-1:0]            op_index,
    input  logic [DATA_SIZE-1:0]            op_data,
    output logic                            op_ack,
    output logic [PTR_WIDTH-1:0]            push_index,
    output logic                            pop_valid,
    output logic [DATA_SIZE-1:0]            pop_data,
    output logic [CH_WIDTH-1:0]             pop_ch,
    output logic [NUM_CH-1:0]               full,
    output logic [NUM_CH-1:0]               empty,
    output logic [NUM_CH-1:0]               head_ready,
    output logic [NUM_CH*(PTR_WIDTH+1)-1:0] size,
    output logic                            error_reg,
    output logic                            error_rem,
    output logic                            error_time
);
    localparam int CW = PTR_WIDTH + 1;
    localparam logic [CW-1:0]        FIFO_FULL = CW'(FIFO_SIZE);
    localparam logic [CW-1:0]        SCAN_MAX  = CW'(SCAN_SIZE);
    localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);

    logic [DATA_SIZE-1:0] mem_q [NUM_CH][FIFO_SIZE];
    logic [FIFO_SIZE-1:0] valid_q [NUM_CH];
    logic [FIFO_SIZE-1:0] valid_d [NUM_CH];
    logic [PTR_WIDTH-1:0] head_q [NUM_CH];
    logic [PTR_WIDTH-1:0] head_d [NUM_CH];
    logic [PTR_WIDTH-1:0] tail_q [NUM_CH];
    logic [PTR_WIDTH-1:0] tail_d [NUM_CH];
    logic [CW-1:0]        occ_q [NUM_CH];
    logic [CW-1:0]        occ_d [NUM_CH];
    logic [CW-1:0]        live_q [NUM_CH];
    logic [CW-1:0]        live_d [NUM_CH];
    logic [CW-1:0]        scan_step [NUM_CH];

    logic                 op_ack_q, op_ack_d;
    logic                 pop_valid_q, pop_valid_d;
    logic [DATA_SIZE-1:0] pop_data_q, pop_data_d;
    logic [CH_WIDTH-1:0]  pop_ch_q, pop_ch_d;
    logic [PTR_WIDTH-1:0] push_index_q, push_index_d;
    logic                 err_reg_q, err_reg_d;
    logic                 err_rem_q, err_rem_d;
    logic                 err_time_q, err_time_d;
    logic                 mem_we;
    logic [PTR_WIDTH-1:0] mem_addr;
    logic                 ch_ok;

    // Distance from head to the first valid slot, or the whole (occ-truncated) window if none.
    function automatic logic [CW-1:0] scan_len(input logic [FIFO_SIZE-1:0] vld,
                                               input logic [PTR_WIDTH-1:0] hd,
                                               input logic [CW-1:0]        occ);
        logic [CW-1:0]        lim;
        logic [CW-1:0]        step;
        logic                 found;
        logic [PTR_WIDTH-1:0] idx;
        lim   = (occ > SCAN_MAX) ? SCAN_MAX : occ;
        step  = '0;
        found = 1'b0;
        idx   = hd;
        if (occ != '0 && !vld[hd]) begin
            step = lim;
            for (int k = 1; k < SCAN_SIZE; k++) begin
                idx = hd + PTR_WIDTH'(k);
                if (!found && CW'(k) < lim && vld[idx]) begin
                    step  = CW'(k);
                    found = 1'b1;
                end
            end
        end
        return step;
    endfunction

    always_comb begin
        size = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            full[c]             = (occ_q[c] == FIFO_FULL);
            empty[c]            = (live_q[c] == '0);
            head_ready[c]       = (occ_q[c] != '0) && valid_q[c][head_q[c]];
            size[c*CW +: CW]    = live_q[c];
            scan_step[c]        = scan_len(valid_q[c], head_q[c], occ_q[c]);
        end
    end

    assign ch_ok = ({1'b0, op_ch} < (CH_WIDTH+1)'(NUM_CH));

    always_comb begin
        valid_d      = valid_q;
        tail_d       = tail_q;
        live_d       = live_q;
        for (int c = 0; c < NUM_CH; c++) begin
            head_d[c] = head_q[c] + scan_step[c][PTR_WIDTH-1:0];
            occ_d[c]  = occ_q[c] - scan_step[c];
        end
        op_ack_d     = 1'b0;
        pop_valid_d  = 1'b0;
        pop_data_d   = pop_data_q;
        pop_ch_d     = pop_ch_q;
        push_index_d = push_index_q;
        err_reg_d    = 1'b0;
        err_rem_d    = 1'b0;
        err_time_d   = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = op_index;
        if (op_flag[2]) begin
            if (!ch_ok) begin
                err_rem_d = 1'b1;
            end else begin
                unique case (op_flag[1:0])
                    2'b00: begin
                        if (occ_q[op_ch] != FIFO_FULL) begin
                            mem_we                          = 1'b1;
                            mem_addr                        = tail_q[op_ch];
                            valid_d[op_ch][tail_q[op_ch]]   = 1'b1;
                            push_index_d                    = tail_q[op_ch];
                            tail_d[op_ch]                   = tail_q[op_ch] + PTR_ONE;
                            occ_d[op_ch]                    = occ_d[op_ch] + CNT_ONE;
                            live_d[op_ch]                   = live_q[op_ch] + CNT_ONE;
                            op_ack_d                        = 1'b1;
                        end else begin
                            err_reg_d = 1'b1;
                        end
                    end
                    2'b01: begin
                        // head_ready implies no scan this cycle, so pop owns head/occ
                        if (head_ready[op_ch]) begin
                            pop_data_d                      = mem_q[op_ch][head_q[op_ch]];
                            pop_ch_d                        = op_ch;
                            pop_valid_d                     = 1'b1;
                            valid_d[op_ch][head_q[op_ch]]   = 1'b0;
                            head_d[op_ch]                   = head_q[op_ch] + PTR_ONE;
                            occ_d[op_ch]                    = occ_q[op_ch] - CNT_ONE;
                            live_d[op_ch]                   = live_q[op_ch] - CNT_ONE;
                            op_ack_d                        = 1'b1;
                        end else if (live_q[op_ch] == '0) begin
                            err_reg_d = 1'b1;
                        end else begin
                            err_time_d = 1'b1;
                        end
                    end
                    2'b10: begin
                        if (valid_q[op_ch][op_index]) begin
                            valid_d[op_ch][op_index] = 1'b0;
                            live_d[op_ch]            = live_q[op_ch] - CNT_ONE;
                            op_ack_d                 = 1'b1;
                        end else begin
                            err_rem_d = 1'b1;
                        end
                    end
                    default: begin
                        if (valid_q[op_ch][op_index]) begin
                            mem_we   = 1'b1;
                            op_ack_d = 1'b1;
                        end else begin
                            err_rem_d = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                valid_q[c] <= '0;
                head_q[c]  <= '0;
                tail_q[c]  <= '0;
                occ_q[c]   <= '0;
                live_q[c]  <= '0;
            end
            op_ack_q     <= 1'b0;
            pop_valid_q  <= 1'b0;
            pop_data_q   <= '0;
            pop_ch_q     <= '0;
            push_index_q <= '0;
            err_reg_q    <= 1'b0;
            err_rem_q    <= 1'b0;
            err_time_q   <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            occ_q        <= occ_d;
            live_q       <= live_d;
            op_ack_q     <= op_ack_d;
            pop_valid_q  <= pop_valid_d;
            pop_data_q   <= pop_data_d;
            pop_ch_q     <= pop_ch_d;
            push_index_q <= push_index_d;
            err_reg_q    <= err_reg_d;
            err_rem_q    <= err_rem_d;
            err_time_q   <= err_time_d;
        end
    end

    // Storage is deliberately not reset; valid bits alone define contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[op_ch][mem_addr] <= op_data;
        end
    end

    assign op_ack     = op_ack_q;
    assign push_index = push_index_q;
    assign pop_valid  = pop_valid_q;
    assign pop_data   = pop_data_q;
    assign pop_ch     = pop_ch_q;
    assign error_reg  = err_reg_q;
    assign error_rem  = err_rem_q;
    assign error_time = err_time_q;

endmodule

// File: doc/indexed_queue_mc.md
# indexed_queue_mc

Multi-channel FIFO with lazy deletion. Holds `NUM_CH` independent queues and accepts one operation per cycle: push, pop, remove by slot index, or modify by slot index. Removed slots become holes. A per-channel head scanner skips up to `SCAN_SIZE` holes per cycle. This block is the parametrised successor to the single-channel order queue, and it adds the following:
- registered pop output with a valid strobe
- push slot-index return
- operation acknowledge
- valid-bit clearing on reset

## Interface
- `DATA_SIZE`, 64, entry width.
- `FIFO_SIZE`, 64, slots per channel; power of 2, ≥2.
- `NUM_CH`, 4, channel count; ≥1.
- `SCAN_SIZE`, 16, slots examined per scan cycle; power of 2, ≤`FIFO_SIZE`.
- `PTR_WIDTH`, `$clog2(FIFO_SIZE)`, derived.
- `CH_WIDTH`, `max(1,$clog2(NUM_CH))`, derived.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `op_flag`  in  3  000/001/010/011 idle, 100 push, 101 pop, 110 remove, 111 modify.
- `op_ch`  in  `CH_WIDTH`  target channel.
- `op_index`  in  `PTR_WIDTH`  slot index for remove/modify.
- `op_data`  in  `DATA_SIZE`  data for push/modify.
- `op_ack`  out  1  registered pulse: the previous cycle's op was accepted.
- `push_index`  out  `PTR_WIDTH`  slot written by the last accepted push; held between pushes.
- `pop_valid`  out  1  registered pulse qualifying `pop_data`/`pop_ch`.
- `pop_data`  out  `DATA_SIZE`  popped entry; held between pops.
- `pop_ch`  out  `CH_WIDTH`  channel of the popped entry; held between pops.
- `full`  out  `NUM_CH`  per channel: `occ==FIFO_SIZE`.
- `empty`  out  `NUM_CH`  per channel: `live==0`.
- `head_ready`  out  `NUM_CH`  per channel: `occ>0 && valid[head]`.
- `size`  out  `NUM_CH*(PTR_WIDTH+1)`  per-channel `live`; channel c occupies bits `[c*(PTR_WIDTH+1) +: PTR_WIDTH+1]`.
- `error_reg`  out  1  registered pulse: push while full, or pop while `live==0`.
- `error_rem`  out  1  registered pulse: remove/modify on an invalid slot, or any non-idle op with `op_ch>=NUM_CH`.
- `error_time`  out  1  registered pulse: pop while `live>0 && !head_ready`.

## Operation
Per-channel state:
- `memory[FIFO_SIZE]` and `valid[FIFO_SIZE]`.
- `head`, `tail` (`PTR_WIDTH`): pointers wrap by truncation.
- `occ` (`PTR_WIDTH+1`): `tail−head` distance, including holes.
- `live` (`PTR_WIDTH+1`): count of valid entries.

Operations (a rejected op changes no state and does not assert `op_ack`):
- Push is accepted iff `occ<FIFO_SIZE`. Effects: `memory[tail]<=op_data`; `valid[tail]<=1`; `push_index<=tail`; `tail`, `occ`, `live` each +1. If rejected, `error_reg` pulses.
- Pop is accepted iff `head_ready[op_ch]`. Effects: `pop_data<=memory[head]`; `pop_ch<=op_ch`; `pop_valid<=1`; `valid[head]<=0`; `head`+1; `occ`−1; `live`−1. If rejected:
  - `live==0` → `error_reg` pulses.
  - otherwise → `error_time` pulses.
- Remove is accepted iff `valid[op_index]`. Effects: `valid<=0`; `live`−1; pointers unchanged. If rejected, `error_rem` pulses.
- Modify is accepted iff `valid[op_index]`. Effect: `memory<=op_data`. If rejected, `error_rem` pulses.
- If `op_ch>=NUM_CH`, `error_rem` pulses and the op has no effect.

Head scanner (every channel, every cycle, independent of `op_flag`):
- The scanner is active when `occ>0 && !valid[head]`.
- Window: slots `head..head+SCAN_SIZE−1` (mod `FIFO_SIZE`), truncated to `occ` slots.
- Result: `head` advances to the first valid slot in the window. If none is valid, `head` advances by `min(SCAN_SIZE,occ)`. `occ` decreases by the same step.
- The scanner reads pre-edge `valid`. A same-cycle remove of the landing slot is therefore handled by the next scan cycle.
- Pop and scan are mutually exclusive per channel because pop requires `valid[head]`.

General rules:
- `occ` counts holes, so `full` can assert while `live<FIFO_SIZE`. This is intended.

## Timing
- Ops are sampled at rising edge N. Their results are visible after edge N:
  - `op_ack`, `pop_*`, `push_index`, `error_*`;
  - `full`, `empty`, `head_ready`, `size`, which are derived from registers.
- Scan latency: a hole run of length g at `head` takes ceil(g/`SCAN_SIZE`) cycles to clear. The run may be created by a head remove or by a pop.
- Back-to-back pops on one channel are allowed while `head_ready` stays high.
- Reset (asserting `reset_n` low, at any time including mid-scan) sets:
  - all pointers, `occ`, `live` and `valid` bits to 0;
  - `pop_valid`, `pop_data`, `pop_ch`, `op_ack`, `push_index`, all errors, `full`, `head_ready` and `size` to 0;
  - `empty` to all-ones.
- Reset does not clear `memory`.

## Test plan
- Reset, then push A,B,C to ch1 → `push_index` 0,1,2; `size[ch1]`=3; `empty`=4'b1101. Pop ch1 → next cycle `pop_valid`=1, `pop_data`=A, `pop_ch`=1.
- `FIFO_SIZE`=64, `SCAN_SIZE`=16: push 40 entries to ch0, remove slots 0–33 → `head_ready[0]` is low for 3 cycles, then high with `head`=34. Pop during the gap → `error_time`, no state change.
- Fill ch2 to 64 entries. A further push → `error_reg`; `full[2]`=1. Pop after the fill → `full[2]` low next cycle. Wrap: 70 push/pop pairs → `push_index` wraps 63→0.
- Remove slot 5 twice → second remove gives `error_rem`. Modify slot 6 with 0xDEAD, then pop up to slot 6 → `pop_data`=0xDEAD.
- Interleave ops across channels: ch0 is scanning while ch3 pushes and pops → ch3 sees no added latency, and each channel's `size` is correct every cycle.
- Drop `reset_n` during an active scan → all outputs reach their reset values immediately. After release, a pop gives `error_reg` and a push returns `push_index`=0.
